// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch / countdown timer family: state
// encoding, BCD widths and BCD digit helpers.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD2_W  = 2 * DIGIT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Limit one BCD digit to lim (used for preset sanitising).
  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] d,
    input logic [DIGIT_W-1:0] lim
  );
    return (d > lim) ? lim : d;
  endfunction

  // Two-digit BCD decrement; 00 wraps to {wrap_tens, 9}.
  function automatic logic [BCD2_W-1:0] bcd2_dec(
    input logic [BCD2_W-1:0]  v,
    input logic [DIGIT_W-1:0] wrap_tens
  );
    logic [BCD2_W-1:0] r;
    if (v == '0) begin
      r = {wrap_tens, DIGIT_W'(9)};
    end else if (v[DIGIT_W-1:0] == '0) begin
      r = {v[BCD2_W-1:DIGIT_W] - DIGIT_W'(1), DIGIT_W'(9)};
    end else begin
      r = {v[BCD2_W-1:DIGIT_W], v[DIGIT_W-1:0] - DIGIT_W'(1)};
    end
    return r;
  endfunction

endpackage

// File: rtl/button_pulse.sv
// Active-low push-button conditioner: 2-flop synchronizer followed by a
// falling-edge detector. One single-cycle pulse per press.
//   clk_i      system clock
//   rst_ni     async active-low reset (flops reset to "released")
//   btn_ni     raw active-low button, asynchronous to clk_i
//   pulse_c_o  one-cycle press pulse (combinational from flops)
module button_pulse (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic pulse_c_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronizer chain plus previous-level flop for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= btn_ni;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_c_o = prev_q & ~sync2_q;

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: loads a preset MM:SS and counts down in centisecond
// steps to 00:00.00, then flags done.
//   Clk, Rst             clock and async active-low reset
//   fStart/fStop/fLoad   active-low buttons (start/resume, pause, load)
//   PresetMin/PresetSec  BCD preset, clamped on load
//   MinBCD/SecBCD/CsBCD  current count in BCD
//   fRun, fDone          registered state flags
module countdown_timer
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              fStart,
  input  logic              fStop,
  input  logic              fLoad,
  input  logic [BCD2_W-1:0] PresetMin,
  input  logic [BCD2_W-1:0] PresetSec,
  output logic [BCD2_W-1:0] MinBCD,
  output logic [BCD2_W-1:0] SecBCD,
  output logic [BCD2_W-1:0] CsBCD,
  output logic              fRun,
  output logic              fDone
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BCD2_W-1:0] min_q, min_d;
  logic [BCD2_W-1:0] sec_q, sec_d;
  logic [BCD2_W-1:0] cs_q, cs_d;
  logic              run_q, done_q;

  logic start_c, stop_c, load_c;
  logic count_zero_c;
  logic [BCD2_W-1:0] cs_dec_c, sec_dec_c, min_dec_c;

  button_pulse u_start (.clk_i(Clk), .rst_ni(Rst), .btn_ni(fStart), .pulse_c_o(start_c));
  button_pulse u_stop  (.clk_i(Clk), .rst_ni(Rst), .btn_ni(fStop),  .pulse_c_o(stop_c));
  button_pulse u_load  (.clk_i(Clk), .rst_ni(Rst), .btn_ni(fLoad),  .pulse_c_o(load_c));

  assign count_zero_c = ({min_q, sec_q, cs_q} == '0);
  assign cs_dec_c     = bcd2_dec(cs_q,  DIGIT_W'(9));
  assign sec_dec_c    = bcd2_dec(sec_q, DIGIT_W'(5));
  assign min_dec_c    = bcd2_dec(min_q, DIGIT_W'(9));

  // Next-state: load beats everything; stop beats start in every state.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    min_d   = min_q;
    sec_d   = sec_q;
    cs_d    = cs_q;

    if (load_c) begin
      min_d   = {clamp_digit(PresetMin[BCD2_W-1:DIGIT_W], DIGIT_W'(9)),
                 clamp_digit(PresetMin[DIGIT_W-1:0],      DIGIT_W'(9))};
      sec_d   = {clamp_digit(PresetSec[BCD2_W-1:DIGIT_W], DIGIT_W'(5)),
                 clamp_digit(PresetSec[DIGIT_W-1:0],      DIGIT_W'(9))};
      cs_d    = '0;
      div_d   = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_c && !stop_c && !count_zero_c) state_d = ST_RUN;
        end
        ST_RUN: begin
          // Divider holds on the stop cycle so the fractional tick survives a pause.
          if (stop_c) begin
            state_d = ST_PAUSE;
          end else if (div_q == DIV_LAST) begin
            div_d = '0;
            cs_d  = cs_dec_c;
            // Borrow chain; minutes cannot underflow since zero stops the run.
            if (cs_q == '0) begin
              sec_d = sec_dec_c;
              if (sec_q == '0) min_d = min_dec_c;
            end
            if ({min_d, sec_d, cs_d} == '0) state_d = ST_DONE;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        ST_PAUSE: begin
          if (start_c && !stop_c) state_d = ST_RUN;
        end
        default: begin
        end
      endcase
    end
  end

  // State, divider, count and flag registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      cs_q    <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      cs_q    <= cs_d;
      run_q   <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign MinBCD = min_q;
  assign SecBCD = sec_q;
  assign CsBCD  = cs_q;
  assign fRun   = run_q;
  assign fDone  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random button traffic,
// every cycle compared with a centisecond-count reference model.
module tb_countdown_timer;

  localparam int unsigned CLK_HZ  = 400;
  localparam int unsigned TICK_HZ = 100;
  localparam int          DIV     = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       Clk;
  logic       Rst;
  logic       fStart, fStop, fLoad;
  logic [7:0] PresetMin, PresetSec;
  logic [7:0] MinBCD, SecBCD, CsBCD;
  logic       fRun, fDone;

  countdown_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .Clk(Clk), .Rst(Rst), .fStart(fStart), .fStop(fStop), .fLoad(fLoad),
    .PresetMin(PresetMin), .PresetSec(PresetSec),
    .MinBCD(MinBCD), .SecBCD(SecBCD), .CsBCD(CsBCD),
    .fRun(fRun), .fDone(fDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: remaining time in centiseconds, mode, cycles spent toward next tick.
  int         m_mode, m_total, m_phase;
  logic [2:0] m_prev, m_p0, m_p1;  // {load, stop, start}

  function automatic int clamp_val(input logic [7:0] raw, input int tens_max);
    int t, o;
    t = int'(raw[7:4]);
    o = int'(raw[3:0]);
    if (t > tens_max) t = tens_max;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [25:0] expect_vec();
    int mi, se, cs;
    mi = m_total / 6000;
    se = (m_total / 100) % 60;
    cs = m_total % 100;
    return {to_bcd(mi), to_bcd(se), to_bcd(cs), m_mode == M_RUN, m_mode == M_DONE};
  endfunction

  function automatic logic [25:0] obs();
    return {MinBCD, SecBCD, CsBCD, fRun, fDone};
  endfunction

  function automatic logic [25:0] dvec(input logic [7:0] mi, input logic [7:0] se,
                                       input logic [7:0] cs, input logic r, input logic d);
    return {mi, se, cs, r, d};
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_total = 0;
    m_phase = 0;
    m_prev  = 3'b111;
    m_p0    = 3'b000;
    m_p1    = 3'b000;
  endtask

  // Presses take effect two edges after the edge that first samples them low.
  task automatic model_step();
    logic [2:0] lv, fall, ev;
    lv     = {fLoad, fStop, fStart};
    fall   = m_prev & ~lv;
    m_prev = lv;
    ev     = m_p1;
    m_p1   = m_p0;
    m_p0   = fall;
    if (ev[2]) begin
      m_total = clamp_val(PresetMin, 9) * 6000 + clamp_val(PresetSec, 5) * 100;
      m_phase = 0;
      m_mode  = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE:  if (ev[0] && !ev[1] && m_total > 0) m_mode = M_RUN;
        M_RUN: begin
          if (ev[1]) begin
            m_mode = M_PAUSE;
          end else begin
            m_phase++;
            if (m_phase == DIV) begin
              m_phase = 0;
              m_total--;
              if (m_total == 0) m_mode = M_DONE;
            end
          end
        end
        M_PAUSE: if (ev[0] && !ev[1]) m_mode = M_RUN;
        default: begin
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [25:0] got, input logic [25:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    check("model", obs(), expect_vec());
  endtask

  // Hold chosen buttons low for one cycle; returns once the press has taken effect.
  task automatic press(input logic l, input logic sp, input logic st);
    fLoad  = ~l;
    fStop  = ~sp;
    fStart = ~st;
    tick();
    fLoad  = 1'b1;
    fStop  = 1'b1;
    fStart = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int hl, hs, ht;
    Rst = 1'b0;
    fStart = 1'b1; fStop = 1'b1; fLoad = 1'b1;
    PresetMin = 8'h00; PresetSec = 8'h00;
    model_reset();
    #22;
    check("reset_state", obs(), 26'd0);
    @(negedge Clk);
    Rst = 1'b1;
    tick();

    // Preset 00:01 counts to zero in 100 ticks.
    PresetMin = 8'h00; PresetSec = 8'h01;
    press(1'b1, 1'b0, 1'b0);
    check("load_0001", obs(), dvec(8'h00, 8'h01, 8'h00, 1'b0, 1'b0));
    press(1'b0, 1'b0, 1'b1);
    check("run_entry", obs(), dvec(8'h00, 8'h01, 8'h00, 1'b1, 1'b0));
    repeat (3) tick();
    check("before_first_tick", obs(), dvec(8'h00, 8'h01, 8'h00, 1'b1, 1'b0));
    tick();
    check("first_tick", obs(), dvec(8'h00, 8'h00, 8'h99, 1'b1, 1'b0));
    repeat (396) tick();
    check("reach_done", obs(), dvec(8'h00, 8'h00, 8'h00, 1'b0, 1'b1));
    press(1'b0, 1'b1, 1'b1);
    check("done_ignores", obs(), dvec(8'h00, 8'h00, 8'h00, 1'b0, 1'b1));

    // Borrow chain from 01:00.
    PresetMin = 8'h01; PresetSec = 8'h00;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    check("borrow_chain", obs(), dvec(8'h00, 8'h59, 8'h99, 1'b1, 1'b0));

    // Pause with divider at 2 keeps the fractional tick.
    press(1'b0, 1'b1, 1'b0);
    check("pause_entry", obs(), dvec(8'h00, 8'h59, 8'h99, 1'b0, 1'b0));
    repeat (50) tick();
    check("pause_hold", obs(), dvec(8'h00, 8'h59, 8'h99, 1'b0, 1'b0));
    press(1'b0, 1'b0, 1'b1);
    tick();
    check("resume_no_tick", obs(), dvec(8'h00, 8'h59, 8'h99, 1'b1, 1'b0));
    tick();
    check("resume_tick", obs(), dvec(8'h00, 8'h59, 8'h98, 1'b1, 1'b0));

    // Coincident presses: stop beats start, load beats start.
    press(1'b0, 1'b1, 1'b1);
    check("stop_over_start", obs(), dvec(8'h00, 8'h59, 8'h98, 1'b0, 1'b0));
    PresetMin = 8'h12; PresetSec = 8'h34;
    press(1'b1, 1'b0, 1'b1);
    check("load_over_start", obs(), dvec(8'h12, 8'h34, 8'h00, 1'b0, 1'b0));
    repeat (8) tick();
    check("idle_after_load", obs(), dvec(8'h12, 8'h34, 8'h00, 1'b0, 1'b0));

    // Clamping and start-at-zero.
    PresetMin = 8'h7A; PresetSec = 8'h9F;
    press(1'b1, 1'b0, 1'b0);
    check("clamp", obs(), dvec(8'h79, 8'h59, 8'h00, 1'b0, 1'b0));
    PresetMin = 8'h00; PresetSec = 8'h00;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check("start_at_zero", obs(), 26'd0);

    // Asynchronous reset mid-run.
    PresetMin = 8'h00; PresetSec = 8'h05;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    repeat (7) tick();
    #3;
    Rst = 1'b0;
    #1;
    check("async_reset", obs(), 26'd0);
    model_reset();
    @(negedge Clk);
    Rst = 1'b1;
    repeat (10) tick();
    check("post_reset_quiet", obs(), 26'd0);

    // Random presets and button traffic, including held buttons.
    for (int it = 0; it < 12; it++) begin
      PresetMin = (it % 2 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      PresetSec = 8'($urandom_range(0, 255));
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      hl = 0; hs = 0; ht = 0;
      for (int c = 0; c < 300; c++) begin
        if (hl > 0) hl--; else if ($urandom_range(0, 59) == 0) hl = $urandom_range(1, 3);
        if (hs > 0) hs--; else if ($urandom_range(0, 29) == 0) hs = $urandom_range(1, 3);
        if (ht > 0) ht--; else if ($urandom_range(0, 19) == 0) ht = $urandom_range(1, 3);
        fLoad  = (hl == 0);
        fStop  = (hs == 0);
        fStart = (ht == 0);
        tick();
      end
      fLoad = 1'b1; fStop = 1'b1; fStart = 1'b1;
      repeat (3) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
